mem_arbiter: RTL

Shares one single-port unified memory between the CPU pipeline's instruction-fetch requester (IF) and its data-access requester (MEM stage, "D"). Each cycle it grants at most one request, drives the memory port, and tracks every issued read through a fixed-latency tag pipeline so read data returns to the right requester. Data accesses normally win, since they belong to the older instruction. A starvation counter guarantees fetch forward progress. The pipeline's PC and IF/ID registers stall on `!if_gnt`; the MEM stage stalls on `!d_gnt`.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/arb_tag_pipe.sv | 37 +++
 rtl/mem_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the unified-memory arbiter.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: owner encoding, default latency/starvation constants, tag entry type.
package mem_arb_pkg;

   // Requester identity carried alongside each in-flight read.
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   // Defaults for the arbiter parameters.
   localparam int MEM_LATENCY_DEF  = 1;
   localparam int STARVE_LIMIT_DEF = 3;

   // One entry of the read-return tag pipeline.
   typedef struct packed {
      logic vld;
      logic owner;
   } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the fetch, data and memory-port signals of the arbiter.
// Latency : n/a (wiring only).
// Backpr. : requesters hold req and fields until their gnt is seen.
// Modports: slave  = arbiter side (takes requests, drives grants and the memory port)
//           master = requester/memory side (drives requests and mem_rdata).
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Instruction-fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // Data (MEM stage) requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // Memory port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_tag_pipe.sv
// Purpose : {valid, owner} shift register that follows each issued read to its return cycle.
// Latency : DEPTH cycles from tag_i to tag_o.
// Backpr. : none; shifts every cycle, clr_i empties every stage synchronously.
// Ports   : clk, clr_i (sync clear), tag_i (stage 0 load), tag_o (last stage).
module arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = MEM_LATENCY_DEF
) (
   input  logic clk,
   input  logic clr_i,
   input  tag_t tag_i,
   output tag_t tag_o
);

   tag_t [DEPTH-1:0] pipe_q;
   tag_t [DEPTH-1:0] pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = tag_i;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port memory between instruction fetch (IF) and data access (D).
// Latency : grant in the request cycle; read data returns MEM_LATENCY cycles after grant.
// Backpr. : a denied requester holds its request; D wins unless IF has waited STARVE_LIMIT cycles.
// Ports   : clk, reset (sync, active-high), bus (mem_arbiter_if.slave: requests, grants,
//           read returns per requester, and the memory port).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic       if_req_ok;
   logic       d_req_ok;
   logic       force_if;
   logic       if_gnt;
   logic       d_gnt;
   logic       mem_en;
   logic       mem_we;
   logic [2:0] starve_q;
   logic [2:0] starve_d;
   tag_t       tag_in;
   tag_t       tag_out;

   // Requests are ignored while reset is held so every grant reads as 0.
   assign if_req_ok = bus.if_req & ~reset;
   assign d_req_ok  = bus.d_req  & ~reset;

   // D normally wins; a fetch that has been denied STARVE_LIMIT cycles in a row wins instead.
   assign force_if = if_req_ok & d_req_ok & (starve_q == LIMIT);
   assign if_gnt   = if_req_ok & (~d_req_ok | force_if);
   assign d_gnt    = d_req_ok & ~force_if;

   assign mem_en = if_gnt | d_gnt;
   assign mem_we = d_gnt & bus.d_we;

   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = d_gnt  ? bus.d_addr :
                          if_gnt ? bus.if_addr : '0;
   assign bus.mem_wdata = mem_we ? bus.d_wdata : '0;

   // Consecutive-denial counter for fetch, saturating at the limit.
   always_comb begin
      starve_d = '0;
      if (if_req_ok && !if_gnt) begin
         starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   // Only reads enter the tag pipe; writes never produce a return.
   assign tag_in.vld   = mem_en & ~mem_we;
   assign tag_in.owner = d_gnt ? OWN_D : OWN_IF;

   arb_tag_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_tag_pipe (
      .clk   (clk),
      .clr_i (reset),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   // Stage contents are still stale in the first reset cycle, so returns are gated as well.
   logic if_rvalid;
   logic d_rvalid;

   assign if_rvalid = tag_out.vld & (tag_out.owner == OWN_IF) & ~reset;
   assign d_rvalid  = tag_out.vld & (tag_out.owner == OWN_D)  & ~reset;

   assign bus.if_rvalid = if_rvalid;
   assign bus.d_rvalid  = d_rvalid;
   assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
   assign bus.d_rdata   = d_rvalid  ? bus.mem_rdata : '0;

endmodule
